// File: rtl/mips_pipe_pkg.sv
// Shared field widths, bit positions and ALU op encodings for the MIPS pipeline control bundles.
package mips_pipe_pkg;

    localparam int unsigned EX_W  = 4;
    localparam int unsigned MEM_W = 3;
    localparam int unsigned WB_W  = 2;

    localparam int unsigned EX_REGDST   = 3;
    localparam int unsigned EX_ALUOP_HI = 2;
    localparam int unsigned EX_ALUOP_LO = 1;
    localparam int unsigned EX_ALUSRC   = 0;

    localparam int unsigned MEM_BRANCH = 2;
    localparam int unsigned MEM_READ   = 1;
    localparam int unsigned MEM_WRITE  = 0;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: compares the load in EX against the source registers read in ID.
module hazard_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  mem_read_ex,
    input  logic [REG_ADDR_W-1:0] rt_ex,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  flush,
    output logic                  hz,
    output logic                  stall
);

    // $0 is hardwired to zero, so a load into it never creates a dependency.
    assign hz    = mem_read_ex & (rt_ex != '0) & ((rt_ex == rs_id) | (rt_ex == rt_id));
    // A flushed instruction is wrong-path; freezing the front end for it would be wasted.
    assign stall = hz & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Optional perf counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [EX_W-1:0]       ex_in,
    input  logic [MEM_W-1:0]      mem_in,
    input  logic [WB_W-1:0]       wb_in,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     pc_plus4_in,
    input  logic [DATA_W-1:0]     read_data1_in,
    input  logic [DATA_W-1:0]     read_data2_in,
    input  logic [DATA_W-1:0]     imm_in,
    input  logic [REG_ADDR_W-1:0] rs_in,
    input  logic [REG_ADDR_W-1:0] rt_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic [EX_W-1:0]       ex_out,
    output logic [MEM_W-1:0]      mem_out,
    output logic [WB_W-1:0]       wb_out,
    output logic [DATA_W-1:0]     pc_plus4_out,
    output logic [DATA_W-1:0]     read_data1_out,
    output logic [DATA_W-1:0]     read_data2_out,
    output logic [DATA_W-1:0]     imm_out,
    output logic [REG_ADDR_W-1:0] rs_out,
    output logic [REG_ADDR_W-1:0] rt_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  valid_out,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      bubble_count
);

    logic [EX_W-1:0]       ex_q;
    logic [MEM_W-1:0]      mem_q;
    logic [WB_W-1:0]       wb_q;
    logic [DATA_W-1:0]     pc_plus4_q, rd1_q, rd2_q, imm_q;
    logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
    logic                  valid_q;
    logic                  hz;
    logic                  bubble;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .mem_read_ex (mem_q[MEM_READ]),
        .rt_ex       (rt_q),
        .rs_id       (rs_in),
        .rt_id       (rt_in),
        .flush       (flush),
        .hz          (hz),
        .stall       (stall)
    );

    assign bubble = flush | hz;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            valid_q    <= 1'b0;
            pc_plus4_q <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else begin
            if (bubble) begin
                ex_q    <= '0;
                mem_q   <= '0;
                wb_q    <= '0;
                valid_q <= 1'b0;
            end else begin
                ex_q    <= ex_in;
                mem_q   <= mem_in;
                wb_q    <= wb_in;
                valid_q <= 1'b1;
            end
            // Data fields load unconditionally; a bubble's payload is ignored downstream.
            pc_plus4_q <= pc_plus4_in;
            rd1_q      <= read_data1_in;
            rd2_q      <= read_data2_in;
            imm_q      <= imm_in;
            rs_q       <= rs_in;
            rt_q       <= rt_in;
            rd_q       <= rd_in;
        end
    end

    assign ex_out         = ex_q;
    assign mem_out        = mem_q;
    assign wb_out         = wb_q;
    assign valid_out      = valid_q;
    assign pc_plus4_out   = pc_plus4_q;
    assign read_data1_out = rd1_q;
    assign read_data2_out = rd2_q;
    assign imm_out        = imm_q;
    assign rs_out         = rs_q;
    assign rt_out         = rt_q;
    assign rd_out         = rd_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

    // Both counters saturate so long runs never wrap back to small values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (bubble && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
        end
    end

    assign stall_count  = stall_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    assign stall_count  = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expected EX contents are queued when ID stimulus is driven.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [3:0]    ex;
        logic [2:0]    mem;
        logic [1:0]    wb;
        logic          flush;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic          exp_stall;
    } stim_t;

    typedef struct packed {
        logic [3:0]    ex;
        logic [2:0]    mem;
        logic [1:0]    wb;
        logic          valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [DW-1:0] pc;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] imm;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    ex_in = '0;
    logic [2:0]    mem_in = '0;
    logic [1:0]    wb_in = '0;
    logic          flush = 1'b0;
    logic [DW-1:0] pc_plus4_in = '0, read_data1_in = '0, read_data2_in = '0, imm_in = '0;
    logic [AW-1:0] rs_in = '0, rt_in = '0, rd_in = '0;
    logic [3:0]    ex_out;
    logic [2:0]    mem_out;
    logic [1:0]    wb_out;
    logic [DW-1:0] pc_plus4_out, read_data1_out, read_data2_out, imm_out;
    logic [AW-1:0] rs_out, rt_out, rd_out;
    logic          valid_out, stall;
    logic [CW-1:0] stall_count, bubble_count;

    int   assertions = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    id_ex_stage #(
        .DATA_W     (DW),
        .REG_ADDR_W (AW),
        .CNT_W      (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ex_in          (ex_in),
        .mem_in         (mem_in),
        .wb_in          (wb_in),
        .flush          (flush),
        .pc_plus4_in    (pc_plus4_in),
        .read_data1_in  (read_data1_in),
        .read_data2_in  (read_data2_in),
        .imm_in         (imm_in),
        .rs_in          (rs_in),
        .rt_in          (rt_in),
        .rd_in          (rd_in),
        .ex_out         (ex_out),
        .mem_out        (mem_out),
        .wb_out         (wb_out),
        .pc_plus4_out   (pc_plus4_out),
        .read_data1_out (read_data1_out),
        .read_data2_out (read_data2_out),
        .imm_out        (imm_out),
        .rs_out         (rs_out),
        .rt_out         (rt_out),
        .rd_out         (rd_out),
        .valid_out      (valid_out),
        .stall          (stall),
        .stall_count    (stall_count),
        .bubble_count   (bubble_count)
    );

    // Drive one ID instruction and queue what EX must hold after the next edge.
    task automatic drive(input stim_t s);
        exp_t e;
        logic bub;
        ex_in = s.ex; mem_in = s.mem; wb_in = s.wb; flush = s.flush;
        rs_in = s.rs; rt_in = s.rt; rd_in = s.rd;
        pc_plus4_in = $urandom(); read_data1_in = $urandom();
        read_data2_in = $urandom(); imm_in = $urandom();
        bub = s.flush | s.exp_stall;
        e.ex    = bub ? 4'b0 : s.ex;
        e.mem   = bub ? 3'b0 : s.mem;
        e.wb    = bub ? 2'b0 : s.wb;
        e.valid = ~bub;
        e.rs = s.rs; e.rt = s.rt; e.rd = s.rd;
        e.pc = pc_plus4_in; e.d1 = read_data1_in; e.d2 = read_data2_in; e.imm = imm_in;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        assertions++;
        if ({ex_out, mem_out, wb_out, valid_out, stall, rs_out, rt_out, rd_out, pc_plus4_out,
             read_data1_out, read_data2_out, imm_out, stall_count, bubble_count} !== '0) begin
            failures++;
            $display("FAIL reset_held: ctrl=%b/%b/%b valid=%b stall=%b rd=%0d got nonzero, want all 0",
                     ex_out, mem_out, wb_out, valid_out, stall, rd_out);
        end
        reset = 1'b1;
        #1;
        assertions++;
        if ({ex_out, mem_out, wb_out, valid_out, stall, stall_count, bubble_count} !== '0) begin
            failures++;
            $display("FAIL reset_release: ex=%b mem=%b wb=%b valid=%b stall=%b, want all 0",
                     ex_out, mem_out, wb_out, valid_out, stall);
        end
    endtask

    task automatic test_pipeline(input string name, input int n, input stim_t tbl[8]);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            drive(tbl[i]);
            #1;
            assertions++;
            if (stall !== tbl[i].exp_stall) begin
                failures++;
                $display("FAIL %s[%0d] stall: got %b want %b", name, i, stall, tbl[i].exp_stall);
            end
            @(posedge clock);
            #1;
            e = sb.pop_front();
            assertions++;
            if ({ex_out, mem_out, wb_out, valid_out} !== {e.ex, e.mem, e.wb, e.valid}) begin
                failures++;
                $display("FAIL %s[%0d] ctrl: got ex=%b mem=%b wb=%b v=%b want ex=%b mem=%b wb=%b v=%b",
                         name, i, ex_out, mem_out, wb_out, valid_out, e.ex, e.mem, e.wb, e.valid);
            end
            if (e.valid) begin
                assertions++;
                if ({rs_out, rt_out, rd_out, pc_plus4_out, read_data1_out, read_data2_out, imm_out}
                    !== {e.rs, e.rt, e.rd, e.pc, e.d1, e.d2, e.imm}) begin
                    failures++;
                    $display("FAIL %s[%0d] data: got rs=%0d rt=%0d rd=%0d pc=%h a=%h b=%h imm=%h want rs=%0d rt=%0d rd=%0d pc=%h a=%h b=%h imm=%h",
                             name, i, rs_out, rt_out, rd_out, pc_plus4_out, read_data1_out,
                             read_data2_out, imm_out, e.rs, e.rt, e.rd, e.pc, e.d1, e.d2, e.imm);
                end
            end
        end
    endtask

    // Fields: ex, mem, wb, flush, rs, rt, rd, exp_stall
    task automatic test_rtype();
        stim_t t[8];
        t[0] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0};
        t[1] = '{4'b0001, 3'b000, 2'b10, 1'b0, 5'd4, 5'd6, 5'd0, 1'b0};
        test_pipeline("rtype", 2, t);
    endtask

    task automatic test_load_use();
        stim_t t[8];
        t[0] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd1, 5'd5, 5'd0, 1'b0};
        t[1] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd5, 5'd6, 5'd7, 1'b1};
        t[2] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd5, 5'd6, 5'd7, 1'b0};
        test_pipeline("load_use", 3, t);
    endtask

    task automatic test_zero_and_store();
        stim_t t[8];
        t[0] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0};
        t[1] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd0, 5'd3, 5'd8, 1'b0};
        t[2] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd2, 5'd7, 5'd0, 1'b0};
        t[3] = '{4'b0001, 3'b001, 2'b00, 1'b0, 5'd1, 5'd7, 5'd0, 1'b1};
        t[4] = '{4'b0001, 3'b001, 2'b00, 1'b0, 5'd1, 5'd7, 5'd0, 1'b0};
        // back-to-back loads, each consumer stalls once
        t[5] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd2, 5'd9, 5'd0, 1'b0};
        t[6] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd9, 5'd10, 5'd0, 1'b1};
        t[7] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd9, 5'd10, 5'd0, 1'b0};
        test_pipeline("zero_store", 8, t);
        t[0] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd10, 5'd4, 5'd11, 1'b1};
        t[1] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd10, 5'd4, 5'd11, 1'b0};
        test_pipeline("b2b_load", 2, t);
    endtask

    task automatic test_flush_priority();
        stim_t t[8];
        t[0] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd1, 5'd9, 5'd0, 1'b0};
        t[1] = '{4'b1100, 3'b000, 2'b10, 1'b1, 5'd9, 5'd2, 5'd4, 1'b0};
        t[2] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd9, 5'd2, 5'd4, 1'b0};
        t[3] = '{4'b1101, 3'b100, 2'b00, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0};
        test_pipeline("flush", 4, t);
    endtask

    task automatic test_reset_mid_stall();
        stim_t t[8];
        t[0] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd1, 5'd12, 5'd0, 1'b0};
        test_pipeline("pre_rst", 1, t);
        drive('{4'b1100, 3'b000, 2'b10, 1'b0, 5'd12, 5'd1, 5'd2, 1'b1});
        void'(sb.pop_back());
        #1;
        assertions++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL mid_stall_pre: stall got %b want 1", stall);
        end
        reset = 1'b0;
        #1;
        assertions++;
        if ({stall, valid_out, mem_out, rt_out} !== '0) begin
            failures++;
            $display("FAIL mid_stall_reset: stall=%b valid=%b mem=%b rt=%0d want all 0",
                     stall, valid_out, mem_out, rt_out);
        end
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_perf_counters();
        stim_t t[8];
        do_reset();
        t[0] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd1, 5'd5, 5'd0, 1'b0};
        t[1] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd5, 5'd6, 5'd7, 1'b1};
        t[2] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd5, 5'd6, 5'd7, 1'b0};
        t[3] = '{4'b1100, 3'b000, 2'b10, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0};
        test_pipeline("perf", 4, t);
`ifdef ID_EX_PERF_CNT_EN
        assertions++;
        if (stall_count !== 8'd1 || bubble_count !== 8'd2) begin
            failures++;
            $display("FAIL perf_counts: got stall=%0d bubble=%0d want 1/2", stall_count, bubble_count);
        end
        t[0] = '{4'b0001, 3'b010, 2'b11, 1'b0, 5'd1, 5'd5, 5'd0, 1'b0};
        t[1] = '{4'b1100, 3'b000, 2'b10, 1'b0, 5'd5, 5'd6, 5'd7, 1'b1};
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            test_pipeline("sat", 2, t);
        end
        assertions++;
        if (stall_count !== '1 || bubble_count !== '1) begin
            failures++;
            $display("FAIL perf_saturate: got stall=%h bubble=%h want all-ones",
                     stall_count, bubble_count);
        end
`else
        assertions++;
        if (stall_count !== '0 || bubble_count !== '0) begin
            failures++;
            $display("FAIL perf_disabled: got stall=%0d bubble=%0d want 0/0", stall_count, bubble_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_use();
        test_zero_and_store();
        test_flush_priority();
        test_reset_mid_stall();
        test_perf_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
